// File: rtl/hm01b0_ingester.sv
// HM01B0 pixel-stream ingester: tracks column/row from hsync/vsync and writes
// each pixel into a double-banked strip buffer feeding the 8x8 block stage.
module hm01b0_ingester #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int STRIP_ROWS = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [7:0]            hm01b0_pixdata,
  input  logic                  hm01b0_hsync,
  input  logic                  hm01b0_vsync,
  output logic                  buf_we,
  output logic                  buf_bank,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [7:0]            buf_wdata,
  output logic                  strip_done,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  line_error,
  output logic                  frame_error
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int SW = (STRIP_ROWS > 1) ? $clog2(STRIP_ROWS) : 1;

  localparam logic [CW-1:0]         COL_MAX   = CW'(WIDTH);
  localparam logic [CW-1:0]         COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0]         ROW_MAX   = RW'(HEIGHT);
  localparam logic [SW-1:0]         SROW_LAST = SW'(STRIP_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(WIDTH);

  localparam logic [1:0] SYNC_WAIT = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  logic [7:0] pix_q;
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [SW-1:0]         srow_q, srow_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  bank_q, bank_d;
  logic                  fs_arm_q, fs_arm_d;

  logic                  we_q, we_d;
  logic                  obank_q, obank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  sd_q, sd_d;
  logic                  fs_q, fs_d;
  logic                  fe_q, fe_d;
  logic                  lerr_q, lerr_d;
  logic                  ferr_q, ferr_d;

  logic hs_fall_s, vs_fall_s, vs_rise_s, active_s, fs_arm_s;

  assign hs_fall_s = hs_prev_q & ~hs_q;
  assign vs_fall_s = vs_prev_q & ~vs_q;
  assign vs_rise_s = vs_q & ~vs_prev_q;
  assign active_s  = (state_q == ACTIVE) | ((state_q == IDLE) & vs_rise_s);
  assign fs_arm_s  = fs_arm_q | ((state_q == IDLE) & vs_rise_s);

  // Input capture; vsync history resets high so a frame in progress at reset
  // release is never mistaken for a fresh rising edge.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pix_q     <= 8'd0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b1;
    end else begin
      pix_q     <= hm01b0_pixdata;
      hs_q      <= hm01b0_hsync;
      vs_q      <= hm01b0_vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
    end
  end

  // Next-state logic for position tracking, buffer writes and error flags.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    srow_d   = srow_q;
    base_d   = base_q;
    bank_d   = bank_q;
    fs_arm_d = fs_arm_q;
    we_d     = 1'b0;
    obank_d  = bank_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sd_d     = 1'b0;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    lerr_d   = lerr_q;
    ferr_d   = ferr_q;

    case (state_q)
      SYNC_WAIT: begin
        col_d  = '0;
        row_d  = '0;
        srow_d = '0;
        base_d = '0;
        bank_d = 1'b0;
        if (!vs_q) begin
          state_d = IDLE;
        end else begin
          state_d = SYNC_WAIT;
        end
      end
      IDLE: begin
        if (vs_rise_s) begin
          state_d  = ACTIVE;
          fs_arm_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        state_d = ACTIVE;
      end
      default: begin
        state_d = SYNC_WAIT;
      end
    endcase

    if (active_s && hs_q && vs_q) begin
      if (row_q >= ROW_MAX) begin
        ferr_d = 1'b1;
      end else if (col_q >= COL_MAX) begin
        lerr_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = base_q + ADDR_WIDTH'(col_q);
        wdata_d = pix_q;
        col_d   = col_q + CW'(1);
        if (fs_arm_s) begin
          fs_d     = 1'b1;
          fs_arm_d = 1'b0;
          lerr_d   = 1'b0;
          ferr_d   = 1'b0;
        end else begin
          fs_d = 1'b0;
        end
        if ((col_q == COL_LAST) && (srow_q == SROW_LAST)) begin
          sd_d   = 1'b1;
          bank_d = ~bank_q;
        end else begin
          sd_d = 1'b0;
        end
      end
    end else begin
      we_d = 1'b0;
    end

    // Line close precedes the frame check so a coincident vsync fall sees the updated row.
    if ((state_q == ACTIVE) && hs_fall_s) begin
      if (col_q != COL_MAX) begin
        lerr_d = 1'b1;
      end else begin
        lerr_d = lerr_d;
      end
      col_d = '0;
      if (row_q < ROW_MAX) begin
        row_d = row_q + RW'(1);
        if (srow_q == SROW_LAST) begin
          srow_d = '0;
          base_d = '0;
        end else begin
          srow_d = srow_q + SW'(1);
          base_d = base_q + ROW_STEP;
        end
      end else begin
        row_d = row_q;
      end
    end else begin
      col_d = col_d;
    end

    if ((state_q == ACTIVE) && vs_fall_s) begin
      fe_d = 1'b1;
      if ((row_d != ROW_MAX) || hs_q || lerr_d) begin
        ferr_d = 1'b1;
      end else begin
        ferr_d = ferr_d;
      end
      state_d  = IDLE;
      fs_arm_d = 1'b0;
      col_d    = '0;
      row_d    = '0;
      srow_d   = '0;
      base_d   = '0;
      bank_d   = 1'b0;
    end else begin
      fe_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= SYNC_WAIT;
      col_q    <= '0;
      row_q    <= '0;
      srow_q   <= '0;
      base_q   <= '0;
      bank_q   <= 1'b0;
      fs_arm_q <= 1'b0;
      we_q     <= 1'b0;
      obank_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'd0;
      sd_q     <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      lerr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      srow_q   <= srow_d;
      base_q   <= base_d;
      bank_q   <= bank_d;
      fs_arm_q <= fs_arm_d;
      we_q     <= we_d;
      obank_q  <= obank_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sd_q     <= sd_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      lerr_q   <= lerr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign buf_we      = we_q;
  assign buf_bank    = obank_q;
  assign buf_addr    = addr_q;
  assign buf_wdata   = wdata_q;
  assign strip_done  = sd_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign line_error  = lerr_q;
  assign frame_error = ferr_q;

endmodule

// File: doc/hm01b0_ingester.md
Name: hm01b0_ingester

Overview:
- Sits directly downstream of the HM01B0 camera interface; runs on the camera pixel clock.
- Captures the 8-bit pixel stream qualified by hsync/vsync and tracks column and row.
- Writes pixels into a double-banked 8-row strip buffer (write port only) for the downstream 8x8 block reorder / DCT stage.
- Flags malformed lines and frames.

Parameters:
- WIDTH, 320: active pixels per line.
- HEIGHT, 240: active lines per frame (must be a multiple of STRIP_ROWS).
- STRIP_ROWS, 8: rows per strip (JPEG block height).
- ADDR_WIDTH, 12: strip-buffer address width; must satisfy 2^ADDR_WIDTH >= STRIP_ROWS*WIDTH.

Ports:
- clock  in  1  pixel clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- hm01b0_pixdata  in  8  camera pixel byte; don't-care (may be X) while hsync low.
- hm01b0_hsync  in  1  high during active pixels of a line.
- hm01b0_vsync  in  1  high during active lines of a frame.
- buf_we  out  1  strip-buffer write enable.
- buf_bank  out  1  strip-buffer bank select.
- buf_addr  out  ADDR_WIDTH  address within bank: (row mod STRIP_ROWS)*WIDTH + col.
- buf_wdata  out  8  pixel byte.
- strip_done  out  1  one-cycle pulse: last pixel of a strip written; buf_bank still shows the completed bank.
- frame_start  out  1  one-cycle pulse coincident with the write of pixel (0,0).
- frame_end  out  1  one-cycle pulse after vsync falls in an active frame.
- line_error  out  1  sticky; cleared on frame_start.
- frame_error  out  1  sticky; cleared on frame_start.

Behaviour:
- Clock and reset: one clock, reset asynchronous active-low, named clock and nreset.
- Reset values: all outputs 0; col, row, bank = 0; state = SYNC_WAIT.
- Input stage: hm01b0_pixdata, hm01b0_hsync and hm01b0_vsync are registered once. All decisions use the registered copies plus one-cycle-delayed copies for edge detection.
- Latency: a pixel sampled at rising edge N appears on buf_we/buf_addr/buf_wdata after edge N+1. All outputs are registered.
- State machine:
  - SYNC_WAIT: ignore all input until registered vsync = 0, then go to IDLE. Frames already in progress at reset release are discarded whole.
  - IDLE: on a vsync rising edge, go to ACTIVE with col = 0, row = 0, and arm frame_start.
  - ACTIVE:
    - On each cycle with hsync = 1 and col < WIDTH: write the pixel (buf_we = 1), then col++.
    - hsync = 1 with col >= WIDTH: pixel dropped, no write, line_error set.
    - hsync falling edge: if col != WIDTH, set line_error. Then col = 0 and row++ (saturating at HEIGHT).
    - When a write has col = WIDTH-1 and (row mod STRIP_ROWS) = STRIP_ROWS-1: pulse strip_done in the same cycle as that write. The bank toggles on the next cycle.
    - Rows >= HEIGHT: pixels dropped, frame_error set.
    - vsync falling edge: pulse frame_end. If row != HEIGHT, or hsync is still high (line cut off), set frame_error. Go to IDLE.
- The first write of each frame carries frame_start = 1, even if lines arrive before a clean row 0 is otherwise detected. frame_start clears both error flags in the same cycle; an error detected in that same cycle wins.
- Bank behaviour:
  - Bank resets to 0 at every frame start, so every frame begins in bank 0.
  - A partial strip at a short frame end produces no strip_done.
- Simultaneous hsync fall and vsync fall: the line close is processed first (row++ and line check), then the frame check uses the updated row.
- Reset asserted mid-frame: outputs clear immediately and asynchronously; after release the block returns to SYNC_WAIT.
- Width rules:
  - col is sized to hold WIDTH; row is sized to hold HEIGHT.
  - buf_addr is computed without a multiplier, using a running base incremented by WIDTH per row and wrapped every STRIP_ROWS rows.

Test Plan:
- Reset release with vsync already high (camera mid-frame): no buf_we until after the first vsync low-to-high transition; the first write is addr 0, bank 0, with frame_start = 1.
- One full nominal frame (320x240, 10-cycle h-blank, 2-line v-blank): exactly 76800 writes and 30 strip_done pulses. Banks alternate 0,1,...,1 and the last strip is in bank 1. Pixel (5,9) writes addr 1*320+5 = 325 in bank 1. One frame_end, no errors.
- Line with 319 pixels on row 3: line_error = 1, frame_error = 1 at frame_end. Both clear on the next frame_start; the next clean frame leaves both at 0.
- Line with 321 pixels: the 321st byte is not written, the last write is addr 319, line_error = 1.
- vsync falls after row 100: frame_end pulses, frame_error = 1, no strip_done for the partial strip. The next frame restarts at bank 0, addr 0.
- nreset pulsed low at row 50: all outputs drop immediately; the remainder of that frame produces no writes.
